// File: rtl/scroll_msg_7seg.sv
// scroll_msg_7seg
//   Scrolls a writable circular message of 3-bit character codes across an
//   active-low 7-segment bank. Scrolling is timed by an internal prescaler
//   (RUN), or advanced one position per rising edge of step (PAUSE/STEP).
//
// Ports
//   CLOCK_50   system clock, all state on rising edge
//   reset      asynchronous active-high reset
//   run        1 = auto-scroll, 0 = pause
//   step       rising edge advances one position while paused
//   dir        0 = scroll left (offset+1), 1 = scroll right (offset-1)
//   clear_pos  synchronous return of offset and prescaler to 0
//   wr_en      message write strobe (wr_addr >= MSG_LEN is ignored)
//   wr_addr    message slot index
//   wr_char    character code to write
//   HEX        active-low segments, bits [7k+6:7k] = digit k, digit 0 rightmost
//   pos        current offset
//   tick       one-cycle pulse on each auto-scroll step
//
// Optional build macro: SCROLL_BLINK_EN
//   Blanks the whole display during the second half of each TICK_DIV period
//   while paused, timed by a free-running blink counter.

module scroll_msg_7seg #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned MSG_LEN    = 8,
  parameter int unsigned TICK_DIV   = 50000000
) (
  input  logic                                        CLOCK_50,
  input  logic                                        reset,
  input  logic                                        run,
  input  logic                                        step,
  input  logic                                        dir,
  input  logic                                        clear_pos,
  input  logic                                        wr_en,
  input  logic [3:0]                                  wr_addr,
  input  logic [2:0]                                  wr_char,
  output logic [7*NUM_DIGITS-1:0]                     HEX,
  output logic [(MSG_LEN > 1 ? $clog2(MSG_LEN) : 1)-1:0] pos,
  output logic                                        tick
);

  localparam int unsigned PW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int unsigned TW = $clog2(TICK_DIV);

  localparam logic [PW-1:0] LAST_POS  = PW'(MSG_LEN - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(TICK_DIV - 1);

  localparam logic [1:0] S_PAUSE = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_STEP  = 2'd2;

  logic [1:0]             state, state_next;
  logic [PW-1:0]          offset, off_inc, off_dec;
  logic [TW-1:0]          presc;
  logic                   step_q;
  logic [2:0]             msg [MSG_LEN];
  logic [7*NUM_DIGITS-1:0] hex_next;
  logic                   wrap, advance, step_rise;

  function automatic logic [6:0] seg7(input logic [2:0] c);
    case (c)
      3'b000:  seg7 = 7'b0001001; // H
      3'b001:  seg7 = 7'b0000110; // E
      3'b011:  seg7 = 7'b1000111; // L
      3'b010:  seg7 = 7'b1000000; // O
      default: seg7 = 7'b1111111; // blank
    endcase
  endfunction

  function automatic logic [2:0] init_char(input int unsigned i);
    case (i)
      0:       init_char = 3'b000;
      1:       init_char = 3'b001;
      2, 3:    init_char = 3'b011;
      4:       init_char = 3'b010;
      default: init_char = 3'b111;
    endcase
  endfunction

  assign wrap      = (state == S_RUN) && (presc == LAST_TICK);
  assign advance   = wrap || (state == S_STEP);
  assign step_rise = step & ~step_q;

  // With MSG_LEN=1 LAST_POS is 0, so both directions hold the offset at 0.
  assign off_inc = (offset == LAST_POS) ? '0 : offset + PW'(1);
  assign off_dec = (offset == '0) ? LAST_POS : offset - PW'(1);

  always_comb begin
    state_next = state;
    case (state)
      S_PAUSE: begin
        if (run)            state_next = S_RUN;
        else if (step_rise) state_next = S_STEP;
      end
      S_RUN:   if (!run) state_next = S_PAUSE;
      default: state_next = S_PAUSE;
    endcase
  end

`ifdef SCROLL_BLINK_EN
  logic [TW-1:0] bcnt;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)                  bcnt <= '0;
    else if (bcnt == LAST_TICK) bcnt <= '0;
    else                        bcnt <= bcnt + TW'(1);
  end
`endif

  always_comb begin
    int unsigned off_u;
    int unsigned idx;
    logic [2:0]  ch;
    off_u    = 32'(offset);
    hex_next = '1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      idx = (off_u + NUM_DIGITS - 1 - k) % MSG_LEN;
      ch  = 3'b111;
      for (int unsigned j = 0; j < MSG_LEN; j++)
        if (idx == j) ch = msg[j];
      hex_next[7*k +: 7] = seg7(ch);
    end
`ifdef SCROLL_BLINK_EN
    if (state == S_PAUSE && bcnt >= TW'(TICK_DIV / 2))
      hex_next = '1;
`endif
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state  <= S_PAUSE;
      offset <= '0;
      presc  <= '0;
      tick   <= 1'b0;
      step_q <= 1'b0;
      HEX    <= '1;
      for (int unsigned i = 0; i < MSG_LEN; i++)
        msg[i] <= init_char(i);
    end else begin
      state  <= state_next;
      step_q <= step;
      tick   <= wrap;
      HEX    <= hex_next;

      if (clear_pos || wrap) presc <= '0;
      else if (state == S_RUN) presc <= presc + TW'(1);

      // clear_pos wins over a coincident advance; tick above still reports the wrap.
      if (clear_pos)    offset <= '0;
      else if (advance) offset <= dir ? off_dec : off_inc;

      for (int unsigned i = 0; i < MSG_LEN; i++)
        if (wr_en && wr_addr == 4'(i)) msg[i] <= wr_char;
    end
  end

  assign pos = offset;

endmodule

// File: tb/tb_scroll_msg_7seg.sv
module tb_scroll_msg_7seg;

  localparam int ND = 8;
  localparam int ML = 8;
  localparam int TD = 4;

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b0, step = 1'b0, dir = 1'b0, clear_pos = 1'b0;
  logic          wr_en = 1'b0;
  logic [3:0]    wr_addr = '0;
  logic [2:0]    wr_char = '0;
  logic [7*ND-1:0] HEX;
  logic [2:0]    pos;
  logic          tick;

  scroll_msg_7seg #(.NUM_DIGITS(ND), .MSG_LEN(ML), .TICK_DIV(TD)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .run(run), .step(step), .dir(dir),
    .clear_pos(clear_pos), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .HEX(HEX), .pos(pos), .tick(tick)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0 = paused, 1 = running, 2 = single step.
  int          m_msg [ML];
  int          m_off, m_pc, m_bc, m_mode, m_prev;
  logic [7*ND-1:0] m_hex;
  logic        m_tick;

  function automatic logic [6:0] segof(input int c);
    case (c)
      0: return 7'b0001001;
      1: return 7'b0000110;
      3: return 7'b1000111;
      2: return 7'b1000000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [7*ND-1:0] render();
    logic [7*ND-1:0] r;
    for (int k = 0; k < ND; k++)
      r[7*k +: 7] = segof(m_msg[(m_off + ND - 1 - k) % ML]);
`ifdef SCROLL_BLINK_EN
    if (m_mode == 0 && m_bc >= TD / 2) r = '1;
`endif
    return r;
  endfunction

  task automatic model_reset();
    int init [5] = '{0, 1, 3, 3, 2};
    for (int i = 0; i < ML; i++) m_msg[i] = (i < 5) ? init[i] : 7;
    m_off = 0; m_pc = 0; m_bc = 0; m_mode = 0; m_prev = 0;
    m_hex = '1; m_tick = 1'b0;
  endtask

  task automatic model_step();
    bit wrapped, adv;
    m_hex   = render();
    wrapped = (m_mode == 1) && (m_pc == TD - 1);
    adv     = wrapped || (m_mode == 2);
    m_tick  = wrapped;
    if (clear_pos)        m_pc = 0;
    else if (m_mode == 1) m_pc = (m_pc + 1) % TD;
    if (clear_pos)        m_off = 0;
    else if (adv)         m_off = (m_off + (dir ? ML - 1 : 1)) % ML;
    if (wr_en && wr_addr < ML) m_msg[wr_addr] = int'(wr_char);
    case (m_mode)
      0:       m_mode = run ? 1 : ((step && !m_prev) ? 2 : 0);
      1:       m_mode = run ? 1 : 0;
      default: m_mode = 0;
    endcase
    m_prev = int'(step);
    m_bc   = (m_bc + 1) % TD;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("hex", 64'(HEX), 64'(m_hex));
    chk("pos", 64'(pos), 64'(m_off));
    chk("tick", 64'(tick), 64'(m_tick));
  endtask

  task automatic cycle();
    @(posedge CLOCK_50);
    if (!reset) model_step();
    @(negedge CLOCK_50);
    compare();
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: wait expired at %0t", nm, $time);
  endtask

  task automatic wait_ticks(input int n, input int budget, input string nm);
    int seen = 0;
    for (int c = 0; c < budget && seen < n; c++) begin
      cycle();
      if (m_tick) seen++;
    end
    if (seen < n) timeout(nm);
  endtask

  task automatic async_reset();
    #1 reset = 1'b1;
    #1;
    model_reset();
    chk("rst_hex", 64'(HEX), 64'(56'hFF_FFFF_FFFF_FFFF));
    chk("rst_pos", 64'(pos), 64'd0);
    chk("rst_tick", 64'(tick), 64'd0);
    cycle();
    reset = 1'b0;
  endtask

  logic [7*ND-1:0] hello;

  initial begin
    hello = {7'b0001001, 7'b0000110, 7'b1000111, 7'b1000111,
             7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111};
    model_reset();
    @(negedge CLOCK_50);
    chk("init_hex", 64'(HEX), 64'(56'hFF_FFFF_FFFF_FFFF));
    chk("init_pos", 64'(pos), 64'd0);
    compare();
    reset = 1'b0;
    cycle();
    chk("hello", 64'(HEX), 64'(hello));

    // Run left: first tick lands offset 1, then E on the left and H on the right.
    run = 1'b1; dir = 1'b0;
    wait_ticks(1, 12, "first_tick");
    chk("tick1_pos", 64'(pos), 64'd1);
    chk("tick1_tick", 64'(tick), 64'd1);
    cycle();
    chk("digit7_E", 64'(HEX[55:49]), 64'(7'b0000110));
    chk("digit0_H", 64'(HEX[6:0]), 64'(7'b0001001));
    wait_ticks(7, 40, "eight_ticks");
    chk("wrap_left_pos", 64'(pos), 64'd0);

    // Wrap right from 0.
    dir = 1'b1;
    wait_ticks(1, 12, "right_tick");
    chk("wrap_right_pos", 64'(pos), 64'd7);
    cycle();
    chk("digit7_blank", 64'(HEX[55:49]), 64'(7'b1111111));

    // Paused single steps.
    run = 1'b0; dir = 1'b0;
    cycle();
    clear_pos = 1'b1;
    cycle();
    clear_pos = 1'b0;
    for (int p = 0; p < 3; p++) begin
      step = 1'b1; cycle();
      step = 1'b0; cycle(); cycle();
    end
    chk("step3_pos", 64'(pos), 64'd3);
    chk("step3_tick", 64'(tick), 64'd0);

    // Write and clear on the wrap cycle.
    run = 1'b1;
    begin
      int c = 0;
      while (!(m_mode == 1 && m_pc == TD - 1) && c < 20) begin cycle(); c++; end
      if (c >= 20) timeout("align_wrap");
    end
    clear_pos = 1'b1; wr_en = 1'b1; wr_addr = 4'd5; wr_char = 3'b001;
    cycle();
    chk("clr_pos", 64'(pos), 64'd0);
    chk("clr_tick", 64'(tick), 64'd1);
    clear_pos = 1'b0; wr_addr = 4'd12; wr_char = 3'b000;
    cycle();
    wr_en = 1'b0;
    chk("digit2_E", 64'(HEX[20:14]), 64'(7'b0000110));
    cycle();

    // Async reset mid-run at offset 5.
    dir = 1'b0;
    begin
      int c = 0;
      while (m_off != 5 && c < 60) begin cycle(); c++; end
      if (c >= 60) timeout("reach_pos5");
    end
    async_reset();
    run = 1'b0;
    cycle();
    chk("restored", 64'(HEX), 64'(hello));

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) run = ~run;
      if ($urandom_range(0, 29) == 0) dir = ~dir;
      step      = ($urandom_range(0, 2) == 0);
      clear_pos = ($urandom_range(0, 39) == 0);
      wr_en     = ($urandom_range(0, 7) == 0);
      wr_addr   = 4'($urandom_range(0, 15));
      wr_char   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) async_reset();
      else cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scroll_msg_7seg.md
Name: scroll_msg_7seg

Overview:
- Clocked, parametrised message scroller for the board's active-low 7-segment bank.
- Holds a writable circular buffer of MSG_LEN 3-bit character codes and rotates it across NUM_DIGITS displays.
- Rotation is driven by an internal prescaler tick, with run/pause, single-step and direction control.
- Replaces the switch-selected static rotation. Sits between the switch/key inputs and the HEX outputs.

Parameters:
- NUM_DIGITS, 8, number of 7-seg digits driven (1..8).
- MSG_LEN, 8, number of character slots in the message buffer (1..16).
- TICK_DIV, 50000000, CLOCK_50 cycles per scroll step (>=2); the default gives 1 Hz.

Ports:
- CLOCK_50  input  1  system clock; all state on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- run  input  1  level; 1 = auto-scroll, 0 = pause.
- step  input  1  level; each 0->1 edge advances one position while paused.
- dir  input  1  0 = scroll left (offset+1), 1 = scroll right (offset-1).
- clear_pos  input  1  synchronous; returns the offset to 0.
- wr_en  input  1  message write strobe.
- wr_addr  input  4  message slot index.
- wr_char  input  3  character code to write.
- HEX  output  7*NUM_DIGITS  active-low segments; bits [7k+6:7k] drive digit k, with digit 0 rightmost.
- pos  output  $clog2(MSG_LEN) (min 1)  current offset.
- tick  output  1  one-cycle pulse on each auto-scroll step.

Behaviour:
- Interface: one clock (CLOCK_50). Reset is asynchronous and active-high (reset).
- Character codes:
  - 000 = H, segments 0001001.
  - 001 = E, segments 0000110.
  - 011 = L, segments 1000111.
  - 010 = O, segments 1000000.
  - Any other code = blank, segments 1111111.
- Reset values:
  - msg[0..4] = H,E,L,L,O; msg[5..MSG_LEN-1] = 111 (blank).
  - offset = 0, prescaler = 0, state = PAUSE.
  - HEX = all 1s, tick = 0, step edge register = 0.
- Mapping: digit k displays msg[(offset + NUM_DIGITS-1-k) mod MSG_LEN]. With the defaults at offset 0, digits 7..0 read "HELLO   ".
- HEX is registered from the current offset and msg; it reflects any change one cycle later.
- States:
  - PAUSE -> RUN when run=1.
  - PAUSE -> STEP on a detected step rising edge while run=0.
  - STEP advances the offset once per dir and returns to PAUSE next cycle. STEP lasts exactly one cycle.
  - RUN -> PAUSE when run=0.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN.
  - On reaching TICK_DIV-1: wraps to 0, tick=1 for that cycle, and the offset advances on the same edge.
  - Holds its value in PAUSE/STEP, so resuming completes the partial period.
- Offset arithmetic is modulo MSG_LEN: MSG_LEN-1 +1 -> 0, and 0 -1 -> MSG_LEN-1. MSG_LEN=1 keeps the offset at 0.
- Step edge detect: registered previous value. Edges seen in RUN are discarded, not queued.
- clear_pos:
  - Sets offset=0 and prescaler=0; the state is unchanged.
  - Has priority over a coincident tick or STEP advance; tick is still asserted if the wrap occurred.
- Writes:
  - When wr_en and wr_addr < MSG_LEN, msg[wr_addr] <= wr_char at the edge. Out-of-range writes are ignored.
  - A write coincident with an advance applies both; HEX shows the new char in the new offset one cycle later.
- Reset asserted mid-scroll forces all reset values immediately (asynchronously). Operation resumes in PAUSE after release.
- pos = offset register, with no extra latency.

Optional Feature:
- Macro: SCROLL_BLINK_EN.
- When defined, while in PAUSE all digits blank (HEX=all 1s) during the second half of each TICK_DIV period.
  - The period is timed by a separate free-running blink counter, because the main prescaler holds in PAUSE.
  - The display returns solid immediately on entering RUN.
- When undefined, the display is solid in all states and no blink counter is built.

Test Plan:
- Defaults with TICK_DIV=4: reset, release, run=0 -> after 1 cycle digits 7..0 show H,E,L,L,O,blank,blank,blank; pos=0; tick=0.
- Run left: run=1, dir=0 -> tick on every 4th cycle. After the first tick pos=1 and digit7=E, digit0=H (segments 0001001). After 8 ticks pos=0.
- Wrap right: dir=1 from pos=0 -> pos=7 on the first tick, digit7=blank.
- Pause/step: run=0, three step pulses -> pos advances by exactly 3 and tick stays 0. A step pulse with run=1 leaves pos driven only by ticks.
- Write + clear: write addr 5 = 001 while clear_pos=1 coincides with a tick -> pos=0, digit2 shows E. Write to addr 12 (MSG_LEN=8) -> no change.
- Async reset mid-run at pos=5 -> HEX all 1s and pos=0 in the same cycle without a clock edge; buffer restored to HELLO. With SCROLL_BLINK_EN: paused digits alternate blank/message every 2 cycles.
